mul_seq_driver: RTL

- Initiator side of the multiplier start/done handshake. Accepts a valid/ready stream of operand pairs and issues one multiply per pair to the multiplier unit.
- Holds the operands stable until the unit signals completion, then captures the 2W-bit product and presents it on a valid/ready result stream.
- Sits between the coefficient fetch logic and the HE multiply datapath.
- Also keeps a per-batch beat count.

---
 rtl/mul_seq_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul_seq_driver.sv
// Initiator for the multiplier start/done handshake: one multiply per accepted
// operand pair, product returned on a valid/ready stream. Optional watchdog: MUL_SEQ_TIMEOUT_EN.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

module mul_seq_driver #(
    parameter int W       = `BIT_WIDTH,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_c,
    input  logic             mul_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_c,
    output logic             out_last,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, GAP} state_t;

    state_t           state_reg, state_next;
    logic             in_ready_reg, in_ready_next;
    logic             mul_start_reg, mul_start_next;
    logic [W-1:0]     mul_a_reg, mul_a_next;
    logic [W-1:0]     mul_b_reg, mul_b_next;
    logic             last_reg, last_next;
    logic             out_valid_reg, out_valid_next;
    logic [2*W-1:0]   out_c_reg, out_c_next;
    logic             out_last_reg, out_last_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             timeout_hit;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            err_reg, err_next;

    // Counter sits at zero outside WAIT, so it restarts on every entry.
    always_comb begin
        to_cnt_next = '0;
        if (state_reg == WAIT) begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end
    end

    assign timeout_hit = (state_reg == WAIT) && !mul_done &&
                         (to_cnt_reg == TO_W'(TIMEOUT - 1));
    assign err_next    = err_reg | timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            to_cnt_reg <= to_cnt_next;
            err_reg    <= err_next;
        end
    end

    assign err = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        mul_a_next    = mul_a_reg;
        mul_b_next    = mul_b_reg;
        last_next     = last_reg;
        out_c_next    = out_c_reg;
        out_last_next = out_last_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    mul_a_next = in_a;
                    mul_b_next = in_b;
                    last_next  = in_last;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (mul_done) begin
                    out_c_next    = mul_c;
                    out_last_next = last_reg;
                    state_next    = OUT;
                end else if (timeout_hit) begin
                    out_c_next    = '0;
                    out_last_next = last_reg;
                    state_next    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    beat_cnt_next = out_last_reg ? '0 : beat_cnt_reg + CNT_W'(1);
                    state_next    = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Handshake flags are registered copies of the upcoming state.
        in_ready_next  = (state_next == IDLE);
        mul_start_next = (state_next == ISSUE);
        out_valid_next = (state_next == OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            mul_start_reg <= 1'b0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            last_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_c_reg     <= '0;
            out_last_reg  <= 1'b0;
            beat_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            mul_start_reg <= mul_start_next;
            mul_a_reg     <= mul_a_next;
            mul_b_reg     <= mul_b_next;
            last_reg      <= last_next;
            out_valid_reg <= out_valid_next;
            out_c_reg     <= out_c_next;
            out_last_reg  <= out_last_next;
            beat_cnt_reg  <= beat_cnt_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign mul_start = mul_start_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign out_valid = out_valid_reg;
    assign out_c     = out_c_reg;
    assign out_last  = out_last_reg;
    assign beat_cnt  = beat_cnt_reg;

endmodule
